ex_mdu: RTL and testbench
=========================

Name: ex_mdu

Overview:
- Multiply/divide unit for the EX stage of the 5-stage pipeline; sits beside the ALU.
- Consumes forwarded rs/rt operands from the ID/EX register and owns the architectural HI/LO registers.
- Executes mult/multu/div/divu over a fixed multi-cycle latency, handles mthi/mtlo, and supplies mfhi/mflo data to the EX/MEM register.
- Raises busy so the ID-stage hazard logic stalls any later MDU instruction.

Parameters:
- MULT_CYCLES, 5, cycles from start to HI/LO commit for mult/multu (valid range ≥1).
- DIV_CYCLES, 10, cycles from start to HI/LO commit for div/divu (valid range ≥1).

Ports:
- clk  input  1  pipeline clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- A  input  32  forwarded rs operand.
- B  input  32  forwarded rt operand.
- MDU_op  input  3  0=none, 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo, 7=reserved (treated as none).
- start  input  1  1-cycle strobe; qualifies MDU_op 1-4 in the current EX cycle.
- RD_sel  input  1  output select: 0=LO (mflo), 1=HI (mfhi).
- busy  output  1  1 while an operation is in flight.
- MDU_out  output  32  selected HI or LO, combinational from the committed registers.

Behaviour:
- Reset (reset=0, asynchronous):
  - HI=0, LO=0, busy=0, counter=0, state IDLE, MDU_out=0.
  - An in-flight operation is discarded and commits nothing.
- States:
  - IDLE: busy=0. On a clock edge with start=1 and MDU_op in 1..4, latch A, B and op, load counter with MULT_CYCLES or DIV_CYCLES, go to RUN.
  - RUN: busy=1. Counter decrements each edge. On the edge where counter==1, write HI/LO and return to IDLE. busy falls in the same cycle the new HI/LO become visible.
- Latency: start sampled at edge T0; results visible after edge T0+N (N = MULT_CYCLES or DIV_CYCLES). busy=1 during cycles T0+1 .. T0+N-1.
- Operands are latched at start; changes on A/B during RUN are ignored.
- Arithmetic:
  - mult: signed 32×32 product, HI=bits 63:32, LO=bits 31:0.
  - multu: unsigned 32×32 product, same split.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Implementation may be combinational-then-delayed or iterative, as long as commit timing is exact.
- Boundary cases:
  - Divide by zero (B=0): HI/LO left unchanged; busy still asserts for DIV_CYCLES.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - mthi/mtlo (MDU_op 5/6, start not required): write A into HI/LO on the edge, only in IDLE. Ignored while busy=1; the hazard unit must stall them.
  - start=1 while busy=1: ignored; no restart, no corruption of the in-flight operation.
  - start=1 with MDU_op in 0,5,6,7: no multi-cycle operation is started.
  - MDU_out reads committed HI/LO only; reading during RUN returns the pre-operation values (stall responsibility lies with hazard logic).
  - reset deasserting mid-cycle: normal operation from the next rising edge.
- Stall contract:
  - The ID stage must stall any MDU-class instruction (mult/div/mthi/mtlo/mfhi/mflo) while busy=1 or while start=1 in EX.
  - ex_mdu performs no stalling itself.

Test Plan:
- Reset and read: reset=0 mid-run, then release → busy=0, HI=LO=0, MDU_out=0 for RD_sel 0 and 1.
- mult signed: A=0xFFFFFFFE (−2), B=3, start at T0 → busy=1 for cycles T0+1..T0+4; after edge T0+5, HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
- multu: A=0xFFFFFFFF, B=2 → after 5 edges, HI=0x00000001, LO=0xFFFFFFFE.
- div signed: A=−7 (0xFFFFFFF9), B=2 → after 10 edges, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Then divu with A=7, B=0 → HI/LO unchanged, busy still high for 10 cycles.
- Conflicts: during mult RUN, assert start with div and a mtlo with A=0x1234 → both ignored; final HI/LO match the mult only.
  - mtlo in IDLE → LO=0x1234, HI untouched.
- Overflow division: div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - Reset asserted at cycle T0+3 of a div → HI/LO=0 and no commit at T0+10.

Source files
------------

// File: rtl/ex_mdu.sv
// ex_mdu: EX-stage multiply/divide unit owning the architectural HI/LO pair.
// Multi-cycle ops latch operands at start and commit HI/LO exactly N edges later;
// the result itself is formed combinationally from the latched operands at commit.
module ex_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDU_op,
    input  logic        start,
    input  logic        RD_sel,
    output logic        busy,
    output logic [31:0] MDU_out
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    op_t           r_op;
    logic [31:0]   r_a;
    logic [31:0]   r_b;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    op_t           w_op_in;
    logic          w_launch;
    logic          w_commit;
    logic          w_is_mul_in;
    logic          w_is_div;
    logic          w_div_zero;
    logic [63:0]   w_prod;
    logic [31:0]   w_dvd;
    logic [31:0]   w_dvs;
    logic [31:0]   w_q;
    logic [31:0]   w_r;
    logic [31:0]   w_hi_res;
    logic [31:0]   w_lo_res;

    assign w_op_in     = op_t'(MDU_op);
    assign w_is_mul_in = (w_op_in == OP_MULT) || (w_op_in == OP_MULTU);
    assign w_is_div    = (r_op == OP_DIV) || (r_op == OP_DIVU);
    assign w_div_zero  = w_is_div && (r_b == '0);

    assign busy    = (r_state == S_RUN);
    assign MDU_out = RD_sel ? r_hi : r_lo;

    // Next-state decode: launch from IDLE on a qualified start, finish when the counter hits 1.
    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (w_op_in inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU})) begin
                    w_launch     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_commit     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Result datapath: signed divide runs on magnitudes, then signs are restored so the
    // quotient truncates toward zero and the remainder follows the dividend; this also
    // yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
    always_comb begin
        w_prod   = '0;
        w_dvd    = r_a;
        w_dvs    = r_b;
        w_q      = '0;
        w_r      = '0;
        w_hi_res = r_hi;
        w_lo_res = r_lo;
        case (r_op)
            OP_MULT:  w_prod = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
            OP_MULTU: w_prod = {32'd0, r_a} * {32'd0, r_b};
            OP_DIV: begin
                w_dvd = r_a[31] ? (~r_a + 32'd1) : r_a;
                w_dvs = r_b[31] ? (~r_b + 32'd1) : r_b;
            end
            default: ;
        endcase
        if (w_dvs != '0) begin
            w_q = w_dvd / w_dvs;
            w_r = w_dvd % w_dvs;
        end
        if (r_op == OP_DIV) begin
            if (r_a[31] ^ r_b[31]) w_q = ~w_q + 32'd1;
            if (r_a[31])           w_r = ~w_r + 32'd1;
        end
        if (w_is_div) begin
            w_hi_res = w_r;
            w_lo_res = w_q;
        end else begin
            w_hi_res = w_prod[63:32];
            w_lo_res = w_prod[31:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Operand latch, latency counter and HI/LO updates (commit or mthi/mtlo in IDLE).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_op  <= OP_NONE;
            r_a   <= '0;
            r_b   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_launch) begin
                r_op  <= w_op_in;
                r_a   <= A;
                r_b   <= B;
                r_cnt <= w_is_mul_in ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_commit && !w_div_zero) begin
                r_hi <= w_hi_res;
                r_lo <= w_lo_res;
            end else if (r_state == S_IDLE) begin
                if (w_op_in == OP_MTHI) r_hi <= A;
                if (w_op_in == OP_MTLO) r_lo <= A;
            end
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed vector table plus hand-written multi-cycle corner sequences for ex_mdu.
module tb_ex_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [2:0]  MDU_op = '0;
    logic        start = 1'b0;
    logic        RD_sel = 1'b0;
    logic        busy;
    logic [31:0] MDU_out;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[11];

    ex_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset   (reset),
        .A       (A),
        .B       (B),
        .MDU_op  (MDU_op),
        .start   (start),
        .RD_sel  (RD_sel),
        .busy    (busy),
        .MDU_out (MDU_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_busy(input string name, input logic exp);
        check(name, {31'd0, busy}, {31'd0, exp});
    endtask

    task automatic check_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
        RD_sel = 1'b1;
        #1 check({name, ".hi"}, MDU_out, eh);
        RD_sel = 1'b0;
        #1 check({name, ".lo"}, MDU_out, el);
    endtask

    // One multi-cycle op: busy must hold for n cycles and drop exactly when the result lands.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n);
        @(negedge clk);
        A = a; B = b; MDU_op = op; start = 1'b1;
        @(posedge clk);
        #1 check_busy({name, ".busy0"}, 1'b1);
        @(negedge clk);
        start = 1'b0; MDU_op = 3'd0; A = $urandom; B = $urandom;
        for (int k = 1; k < n; k++) begin
            @(posedge clk);
            #1 check_busy($sformatf("%s.busy%0d", name, k), 1'b1);
        end
        @(posedge clk);
        #1 check_busy({name, ".done"}, 1'b0);
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        MDU_op = op; A = a;
        @(negedge clk);
        MDU_op = 3'd0;
    endtask

    initial begin
        vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3,         32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'd2,         32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,         32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{3'd4, 32'd7,        32'd0,         32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{3'd4, 32'd100,      32'd7,         32'h00000002, 32'h0000000E};
        vecs[6]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[8]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[10] = '{3'd3, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};

        // Reset state
        #2 check_busy("rst.busy", 1'b0);
        check_hilo("rst", 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Vector table
        foreach (vecs[i]) begin
            run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   (vecs[i].op inside {3'd1, 3'd2}) ? MC : DC);
            check_hilo($sformatf("v%0d", i), vecs[i].hi, vecs[i].lo);
        end

        // Conflicting start and mtlo during a mult are ignored; reads return old HI/LO
        @(negedge clk);
        A = 32'd3; B = 32'd5; MDU_op = 3'd1; start = 1'b1;
        @(posedge clk);
        #1 check_busy("cf.busy0", 1'b1);
        @(negedge clk);
        A = 32'd1; B = 32'd1; MDU_op = 3'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        A = 32'h1234; MDU_op = 3'd6; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        MDU_op = 3'd0;
        check_hilo("cf.during", 32'hFFFFFFFE, 32'h00000002);
        for (int k = 3; k < MC; k++) begin
            @(posedge clk);
            #1 check_busy($sformatf("cf.busy%0d", k), 1'b1);
        end
        @(posedge clk);
        #1 check_busy("cf.done", 1'b0);
        check_hilo("cf", 32'h0, 32'h0000000F);

        // mtlo / mthi in IDLE
        mt(3'd6, 32'h1234);
        check_hilo("mtlo", 32'h0, 32'h1234);
        mt(3'd5, 32'hCAFE);
        check_hilo("mthi", 32'hCAFE, 32'h1234);

        // start with non-multicycle ops launches nothing
        @(negedge clk);
        A = 32'hBEEF; B = 32'd1; MDU_op = 3'd5; start = 1'b1;
        @(posedge clk);
        #1 check_busy("st5.busy", 1'b0);
        @(negedge clk);
        A = 32'd9; MDU_op = 3'd7;
        @(posedge clk);
        #1 check_busy("st7.busy", 1'b0);
        @(negedge clk);
        MDU_op = 3'd0;
        @(posedge clk);
        #1 check_busy("st0.busy", 1'b0);
        @(negedge clk);
        start = 1'b0;
        check_hilo("st", 32'hBEEF, 32'h1234);

        // Asynchronous reset in the middle of a divide discards it
        @(negedge clk);
        A = 32'd100; B = 32'd7; MDU_op = 3'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; MDU_op = 3'd0;
        repeat (3) @(posedge clk);
        #1 check_busy("mr.busy", 1'b1);
        #1 reset = 1'b0;
        #1 check_busy("mr.rstbusy", 1'b0);
        check_hilo("mr.rst", 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (DC) @(posedge clk);
        #1 check_busy("mr.after", 1'b0);
        check_hilo("mr.after", 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
